// File: rtl/md5_pkg.sv
// Shared MD5 constants, FSM state type and per-step index/shift helpers
// for the iterative md5_stream engine.
package md5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hEFCDAB89;
  localparam logic [31:0] IV_C = 32'h98BADCFE;
  localparam logic [31:0] IV_D = 32'h10325476;
  localparam logic [127:0] IV = {IV_A, IV_B, IV_C, IV_D};

  localparam logic [31:0] K_TBL [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amount depends only on the round and the step position mod 4.
  function automatic logic [4:0] shift_amt(input logic [5:0] i);
    logic [4:0] r;
    case ({i[5:4], i[1:0]})
      4'h0: r = 5'd7;
      4'h1: r = 5'd12;
      4'h2: r = 5'd17;
      4'h3: r = 5'd22;
      4'h4: r = 5'd5;
      4'h5: r = 5'd9;
      4'h6: r = 5'd14;
      4'h7: r = 5'd20;
      4'h8: r = 5'd4;
      4'h9: r = 5'd11;
      4'hA: r = 5'd16;
      4'hB: r = 5'd23;
      4'hC: r = 5'd6;
      4'hD: r = 5'd10;
      4'hE: r = 5'd15;
      default: r = 5'd21;
    endcase
    return r;
  endfunction

  // 4-bit arithmetic gives the mod-16 wrap for free.
  function automatic logic [3:0] msg_idx(input logic [5:0] i);
    logic [3:0] j;
    logic [3:0] g;
    j = i[3:0];
    case (i[5:4])
      2'd0:    g = j;
      2'd1:    g = j * 4'd5 + 4'd1;
      2'd2:    g = j * 4'd3 + 4'd5;
      default: g = j * 4'd7;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step: mixes a message word into {a,b,c,d}
// using the round's boolean function, constant and rotate amount.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] m_i,
  input  logic [31:0] k_i,
  input  logic [4:0]  s_i,
  input  logic [1:0]  round_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o
);

  logic [31:0] f;
  logic [31:0] sum;
  logic [63:0] dbl;

  always_comb begin
    case (round_i)
      2'd0:    f = (b_i & c_i) | (~b_i & d_i);
      2'd1:    f = (d_i & b_i) | (~d_i & c_i);
      2'd2:    f = b_i ^ c_i ^ d_i;
      default: f = c_i ^ (b_i | ~d_i);
    endcase
  end

  // Rotate-left via a doubled word: the upper half after the shift is rotl.
  assign sum = a_i + f + k_i + m_i;
  assign dbl = {sum, sum} << s_i;

  assign a_o = d_i;
  assign b_o = b_i + dbl[63:32];
  assign c_o = b_i;
  assign d_o = c_i;

endmodule

// File: rtl/md5_stream.sv
// Iterative MD5 compression engine: one 512-bit block per transaction,
// STEPS_PER_CYCLE chained steps per clock, chaining value kept across blocks.
module md5_stream
  import md5_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              blk_valid_i,
  output logic              blk_ready_o,
  input  logic [15:0][31:0] blk_i,
  input  logic              first_i,
  input  logic              last_i,
  output logic              digest_valid_o,
  input  logic              digest_ready_i,
  output logic [127:0]      digest_o,
  output logic              busy_o
);

  localparam int S = STEPS_PER_CYCLE;

  if (!(S == 1 || S == 2 || S == 4 || S == 8 || S == 16)) begin : g_bad_steps
    $error("md5_stream: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_t            state_q, state_d;
  logic [5:0]        i_q, i_d;
  logic [15:0][31:0] blk_q, blk_d;
  logic              last_q, last_d;
  logic [31:0]       a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [3:0][31:0]  h_q, h_d;
  logic [3:0][31:0]  h_new;
  logic [127:0]      digest_q, digest_d;
  logic              last_step;

  logic [31:0] wa [0:S];
  logic [31:0] wb [0:S];
  logic [31:0] wc [0:S];
  logic [31:0] wd [0:S];

  assign wa[0] = a_q;
  assign wb[0] = b_q;
  assign wc[0] = c_q;
  assign wd[0] = d_q;

  genvar gi;
  for (gi = 0; gi < S; gi++) begin : g_step
    logic [5:0] idx;
    assign idx = i_q + 6'(gi);

    md5_step u_step (
      .a_i     (wa[gi]),
      .b_i     (wb[gi]),
      .c_i     (wc[gi]),
      .d_i     (wd[gi]),
      .m_i     (blk_q[msg_idx(idx)]),
      .k_i     (K_TBL[idx]),
      .s_i     (shift_amt(idx)),
      .round_i (idx[5:4]),
      .a_o     (wa[gi+1]),
      .b_o     (wb[gi+1]),
      .c_o     (wc[gi+1]),
      .d_o     (wd[gi+1])
    );
  end

  // h_q holds the chaining value loaded at accept, so it doubles as H_in.
  assign h_new[3]  = h_q[3] + wa[S];
  assign h_new[2]  = h_q[2] + wb[S];
  assign h_new[1]  = h_q[1] + wc[S];
  assign h_new[0]  = h_q[0] + wd[S];
  assign last_step = (i_q == 6'(64 - S));

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    blk_d    = blk_q;
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    h_d      = h_q;
    digest_d = digest_q;
    case (state_q)
      ST_IDLE: begin
        if (blk_valid_i) begin
          blk_d   = blk_i;
          last_d  = last_i;
          i_d     = 6'd0;
          state_d = ST_RUN;
          if (first_i) begin
            h_d = IV;
            a_d = IV_A;
            b_d = IV_B;
            c_d = IV_C;
            d_d = IV_D;
          end else begin
            a_d = h_q[3];
            b_d = h_q[2];
            c_d = h_q[1];
            d_d = h_q[0];
          end
        end
      end
      ST_RUN: begin
        a_d = wa[S];
        b_d = wb[S];
        c_d = wc[S];
        d_d = wd[S];
        i_d = i_q + 6'(S);
        if (last_step) begin
          h_d = h_new;
          if (last_q) begin
            digest_d = h_new;
            state_d  = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (digest_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      i_q      <= 6'd0;
      blk_q    <= '0;
      last_q   <= 1'b0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      c_q      <= 32'd0;
      d_q      <= 32'd0;
      h_q      <= IV;
      digest_q <= 128'd0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      blk_q    <= blk_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      h_q      <= h_d;
      digest_q <= digest_d;
    end
  end

  assign blk_ready_o    = (state_q == ST_IDLE);
  assign busy_o         = (state_q == ST_RUN);
  assign digest_valid_o = (state_q == ST_HOLD);
  assign digest_o       = digest_q;

endmodule

// File: tb/tb_md5_stream.sv
// Directed bench for md5_stream: main instance at 4 steps/cycle plus
// 1- and 16-step instances run in lockstep on "abc".
module tb_md5_stream;

  localparam logic [127:0] IV_W   = 128'h67452301_EFCDAB89_98BADCFE_10325476;
  localparam logic [127:0] D_EMPTY = 128'hD98C1DD4_04B2008F_980980E9_7E42F8EC;
  localparam logic [127:0] D_ABC   = 128'h98500190_B04FD23C_7D3F96D6_727FE128;

  localparam logic [31:0] TK [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  localparam int TR [64] = '{
    7, 12, 17, 22, 7, 12, 17, 22, 7, 12, 17, 22, 7, 12, 17, 22,
    5,  9, 14, 20, 5,  9, 14, 20, 5,  9, 14, 20, 5,  9, 14, 20,
    4, 11, 16, 23, 4, 11, 16, 23, 4, 11, 16, 23, 4, 11, 16, 23,
    6, 10, 15, 21, 6, 10, 15, 21, 6, 10, 15, 21, 6, 10, 15, 21
  };

  logic              clk = 1'b0;
  logic              rst_i;
  logic              blk_valid, aux_valid, first, last, dready, aux_dready;
  logic [15:0][31:0] blk;
  logic              ready_m, dvalid_m, busy_m;
  logic              ready_1, dvalid_1, busy_1;
  logic              ready_16, dvalid_16, busy_16;
  logic [127:0]      dig_m, dig_1, dig_16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  md5_stream #(.STEPS_PER_CYCLE(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .blk_valid_i(blk_valid), .blk_ready_o(ready_m),
    .blk_i(blk), .first_i(first), .last_i(last), .digest_valid_o(dvalid_m),
    .digest_ready_i(dready), .digest_o(dig_m), .busy_o(busy_m)
  );
  md5_stream #(.STEPS_PER_CYCLE(1)) dut_s1 (
    .clk_i(clk), .rst_i(rst_i), .blk_valid_i(aux_valid), .blk_ready_o(ready_1),
    .blk_i(blk), .first_i(first), .last_i(last), .digest_valid_o(dvalid_1),
    .digest_ready_i(aux_dready), .digest_o(dig_1), .busy_o(busy_1)
  );
  md5_stream #(.STEPS_PER_CYCLE(16)) dut_s16 (
    .clk_i(clk), .rst_i(rst_i), .blk_valid_i(aux_valid), .blk_ready_o(ready_16),
    .blk_i(blk), .first_i(first), .last_i(last), .digest_valid_o(dvalid_16),
    .digest_ready_i(aux_dready), .digest_o(dig_16), .busy_o(busy_16)
  );

  function automatic logic [127:0] md5_model(input logic [127:0] h, input logic [15:0][31:0] m);
    logic [31:0] a, b, c, d, f, t;
    int g;
    a = h[127:96]; b = h[95:64]; c = h[63:32]; d = h[31:0];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
      t = a + f + TK[i] + m[g];
      t = (t << TR[i]) | (t >> (32 - TR[i]));
      a = d; d = c; c = b; b = b + t;
    end
    return {h[127:96] + a, h[95:64] + b, h[63:32] + c, h[31:0] + d};
  endfunction

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic send_main(input logic [15:0][31:0] m, input logic f, input logic l);
    blk = m; first = f; last = l; blk_valid = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0;
    $display("block sent first=%0b last=%0b m0=%h t=%0t", f, l, m[0], $time);
  endtask

  task automatic wait_digest(input string name, input int exp_lat);
    int cyc = 0;
    while (dvalid_m !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_latency"}, 128'(cyc), 128'(exp_lat));
    $display("digest %s = %h after %0d cycles", name, dig_m, cyc);
  endtask

  task automatic release_digest(input string name);
    dready = 1'b1;
    @(posedge clk); #1;
    dready = 1'b0;
    chk({name, "_ready_after_take"}, 128'(ready_m), 128'(1));
    chk({name, "_valid_after_take"}, 128'(dvalid_m), 128'(0));
  endtask

  initial begin
    logic [15:0][31:0] m_empty, m_abc, m_a1, m_a2;
    logic [127:0] h1, h2, h3;
    int lat1, lat4, lat16, cyc;
    logic bp_bad, saw_dv;

    m_empty = '0; m_empty[0] = 32'h00000080;
    m_abc   = '0; m_abc[0] = 32'h80636261; m_abc[14] = 32'h00000018;
    m_a1 = '0;
    for (int w = 0; w < 14; w++) m_a1[w] = 32'h61616161;
    m_a1[14] = 32'h00000080;
    m_a2 = '0; m_a2[14] = 32'h000001C0;
    h1 = md5_model(IV_W, m_a1);
    h2 = md5_model(h1, m_a2);
    h3 = md5_model(h2, m_a2);

    rst_i = 1'b0; blk_valid = 1'b0; aux_valid = 1'b0; first = 1'b0; last = 1'b0;
    dready = 1'b0; aux_dready = 1'b0; blk = '0;
    #12;
    chk("rst_ready", 128'(ready_m), 128'(1));
    chk("rst_dvalid", 128'(dvalid_m), 128'(0));
    chk("rst_digest", dig_m, 128'd0);
    chk("rst_busy", 128'(busy_m), 128'(0));
    #3 rst_i = 1'b1;
    @(posedge clk); #1;

    // "abc" on all three step widths at once, then hold the digest 20+ cycles
    blk = m_abc; first = 1'b1; last = 1'b1; blk_valid = 1'b1; aux_valid = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0; aux_valid = 1'b0;
    $display("block sent to all widths m0=%h t=%0t", m_abc[0], $time);
    chk("abc_busy", 128'(busy_m), 128'(1));
    chk("abc_ready_in_run", 128'(ready_m), 128'(0));
    lat1 = -1; lat4 = -1; lat16 = -1; bp_bad = 1'b0;
    for (cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk); #1;
      if (dvalid_1 === 1'b1 && lat1 < 0) lat1 = cyc;
      if (dvalid_m === 1'b1 && lat4 < 0) lat4 = cyc;
      if (dvalid_16 === 1'b1 && lat16 < 0) lat16 = cyc;
      if (lat4 > 0 && cyc <= lat4 + 20) begin
        if (dvalid_m !== 1'b1 || dig_m !== D_ABC || ready_m !== 1'b0) bp_bad = 1'b1;
      end
      if (lat4 > 0) begin
        blk = m_empty; first = 1'b1; last = 1'b1; blk_valid = 1'b1;
      end
    end
    blk_valid = 1'b0;
    chk("abc_lat_s1", 128'(lat1), 128'(64));
    chk("abc_lat_s4", 128'(lat4), 128'(16));
    chk("abc_lat_s16", 128'(lat16), 128'(4));
    chk("abc_digest_s1", dig_1, D_ABC);
    chk("abc_digest_s4", dig_m, D_ABC);
    chk("abc_digest_s16", dig_16, D_ABC);
    chk("backpressure_hold", 128'(bp_bad), 128'(0));
    aux_dready = 1'b1;
    release_digest("abc");
    aux_dready = 1'b0;
    chk("abc_busy_after_take", 128'(busy_m), 128'(0));
    chk("abc_aux_ready", 128'({ready_1, ready_16}), 128'(2'b11));

    send_main(m_empty, 1'b1, 1'b1);
    wait_digest("empty", 16);
    chk("empty_digest", dig_m, D_EMPTY);
    release_digest("empty");

    // two-block message: no digest after block 1, old digest held meanwhile
    send_main(m_a1, 1'b1, 1'b0);
    cyc = 0; saw_dv = 1'b0;
    while (ready_m !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (dvalid_m !== 1'b0) saw_dv = 1'b1;
    end
    chk("a56_blk1_turnaround", 128'(cyc), 128'(16));
    chk("a56_blk1_no_digest", 128'(saw_dv), 128'(0));
    chk("a56_digest_held", dig_m, D_EMPTY);
    send_main(m_a2, 1'b0, 1'b1);
    wait_digest("a56", 16);
    chk("a56_digest", dig_m, h2);
    release_digest("a56");

    send_main(m_a2, 1'b0, 1'b1);
    wait_digest("continue", 16);
    chk("continue_digest", dig_m, h3);
    release_digest("continue");

    // reset while step 28..31 is being evaluated
    send_main(m_empty, 1'b1, 1'b1);
    repeat (7) @(posedge clk);
    #1 rst_i = 1'b0;
    #1;
    chk("midrst_ready", 128'(ready_m), 128'(1));
    chk("midrst_busy", 128'(busy_m), 128'(0));
    chk("midrst_dvalid", 128'(dvalid_m), 128'(0));
    chk("midrst_digest", dig_m, 128'd0);
    #1 rst_i = 1'b1;
    @(posedge clk); #1;
    send_main(m_abc, 1'b1, 1'b1);
    wait_digest("abc_after_rst", 16);
    chk("abc_after_rst_digest", dig_m, D_ABC);
    release_digest("abc_after_rst");

    // offers during RUN must be ignored
    send_main(m_abc, 1'b1, 1'b1);
    blk = m_a1; first = 1'b0; last = 1'b0; blk_valid = 1'b1;
    wait_digest("abc_noisy", 16);
    blk_valid = 1'b0;
    chk("abc_noisy_digest", dig_m, D_ABC);
    release_digest("abc_noisy");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
